// File: rtl/m_definitions.svh
// Select encodings shared by the M-extension sequencer and its datapath.
// Each mux has a width macro and one macro per encoding.
`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH

// Remainder / multiplicand register (R) select
`define MUX_R_LENGTH      3
`define MUX_R_KEEP        3'd0
`define MUX_R_A           3'd1
`define MUX_R_A_NEG       3'd2
`define MUX_R_SUB_KEEP    3'd3
`define MUX_R_MULT_LOWER  3'd4

// Divisor / multiplier register (D) select
`define MUX_D_LENGTH      2
`define MUX_D_KEEP        2'd0
`define MUX_D_B           2'd1
`define MUX_D_B_NEG       2'd2
`define MUX_D_SHR         2'd3

// Quotient / upper-product register (Z) select
`define MUX_Z_LENGTH      2
`define MUX_Z_KEEP        2'd0
`define MUX_Z_ZERO        2'd1
`define MUX_Z_SHL_ADD     2'd2
`define MUX_Z_MULT_UPPER  2'd3

// Multiplier operand A select
`define MUX_MULTA_LENGTH      2
`define MUX_MULTA_ZERO        2'd0
`define MUX_MULTA_R_SIGNED    2'd1
`define MUX_MULTA_R_UNSIGNED  2'd2

// Multiplier operand B select
`define MUX_MULTB_LENGTH      2
`define MUX_MULTB_ZERO        2'd0
`define MUX_MULTB_D_SIGNED    2'd1
`define MUX_MULTB_D_UNSIGNED  2'd2

`endif

// File: rtl/m_sequencer.sv
// m_sequencer: control FSM for the RV32M multiply/divide unit.
// Steps the datapath muxes through load, pipelined multiply or a
// 32-step restoring divide, then reports how to form the result.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   start                request valid (sampled only in IDLE)
//   funct3               M-op code (MUL..REMU)
//   rs1_msb, rs2_msb     operand sign bits
//   rs2_zero             divisor is zero
//   mux_R/D/Z            datapath register selects
//   mux_multA/multB      multiplier operand selects
//   busy                 operation in progress
//   done                 one-cycle completion pulse
//   result_sel           00 Z, 01 R, 10 all-ones, 11 rs1
//   negate_result        result is negated downstream
`include "m_definitions.svh"

module m_sequencer #(
    parameter int MUL_WAIT = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [2:0]                     funct3,
    input  logic                           rs1_msb,
    input  logic                           rs2_msb,
    input  logic                           rs2_zero,
    output logic [`MUX_R_LENGTH-1:0]       mux_R,
    output logic [`MUX_D_LENGTH-1:0]       mux_D,
    output logic [`MUX_Z_LENGTH-1:0]       mux_Z,
    output logic [`MUX_MULTA_LENGTH-1:0]   mux_multA,
    output logic [`MUX_MULTB_LENGTH-1:0]   mux_multB,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     result_sel,
    output logic                           negate_result
);

    localparam int WW = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_MUL_WB,
        ST_DIV_ITER,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            rs1_msb_q, rs1_msb_d;
    logic            rs2_msb_q, rs2_msb_d;
    logic            rs2_zero_q, rs2_zero_d;
    logic [4:0]      div_cnt_q, div_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            is_mul;
    logic            s_a;
    logic            s_b;
    logic [`MUX_MULTA_LENGTH-1:0] mult_a_sel;
    logic [`MUX_MULTB_LENGTH-1:0] mult_b_sel;

    // funct3[2] clear selects the multiply group
    assign is_mul = ~op_q[2];

    always_comb begin
        s_a = 1'b0;
        s_b = 1'b0;
        unique case (op_q)
            3'b000, 3'b001: begin
                s_a = 1'b1;
                s_b = 1'b1;
            end
            3'b010: s_a = 1'b1;
            3'b100, 3'b110: begin
                s_a = 1'b1;
                s_b = 1'b1;
            end
            default: begin
                s_a = 1'b0;
                s_b = 1'b0;
            end
        endcase
    end

    assign mult_a_sel = s_a ? `MUX_MULTA_R_SIGNED : `MUX_MULTA_R_UNSIGNED;
    assign mult_b_sel = s_b ? `MUX_MULTB_D_SIGNED : `MUX_MULTB_D_UNSIGNED;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'b000;
            rs1_msb_q  <= 1'b0;
            rs2_msb_q  <= 1'b0;
            rs2_zero_q <= 1'b0;
            div_cnt_q  <= 5'd0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs1_msb_q  <= rs1_msb_d;
            rs2_msb_q  <= rs2_msb_d;
            rs2_zero_q <= rs2_zero_d;
            div_cnt_q  <= div_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rs1_msb_d     = rs1_msb_q;
        rs2_msb_d     = rs2_msb_q;
        rs2_zero_d    = rs2_zero_q;
        div_cnt_d     = div_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mux_R         = `MUX_R_KEEP;
        mux_D         = `MUX_D_KEEP;
        mux_Z         = `MUX_Z_KEEP;
        mux_multA     = `MUX_MULTA_ZERO;
        mux_multB     = `MUX_MULTB_ZERO;
        done          = 1'b0;
        result_sel    = 2'b00;
        negate_result = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d       = funct3;
                    rs1_msb_d  = rs1_msb;
                    rs2_msb_d  = rs2_msb;
                    rs2_zero_d = rs2_zero;
                    state_d    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                mux_Z = `MUX_Z_ZERO;
                if (is_mul) begin
                    mux_R   = `MUX_R_A;
                    mux_D   = `MUX_D_B;
                    state_d = ST_MUL_ISSUE;
                end else begin
                    // divide works on magnitudes; sign fixed up at the end
                    mux_R = (s_a & rs1_msb_q) ? `MUX_R_A_NEG : `MUX_R_A;
                    mux_D = (s_b & rs2_msb_q) ? `MUX_D_B_NEG : `MUX_D_B;
                    if (rs2_zero_q) begin
                        state_d = ST_DONE;
                    end else begin
                        div_cnt_d = 5'd31;
                        state_d   = ST_DIV_ITER;
                    end
                end
            end

            ST_MUL_ISSUE: begin
                mux_multA = mult_a_sel;
                mux_multB = mult_b_sel;
                if (MUL_WAIT == 0) begin
                    state_d = ST_MUL_WB;
                end else begin
                    wait_cnt_d = WW'(MUL_WAIT - 1);
                    state_d    = ST_MUL_WAIT;
                end
            end

            ST_MUL_WAIT: begin
                mux_multA = mult_a_sel;
                mux_multB = mult_b_sel;
                if (wait_cnt_q == '0) begin
                    state_d = ST_MUL_WB;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end

            // operand selects stay up: the upper-word slice depends on them
            ST_MUL_WB: begin
                mux_multA = mult_a_sel;
                mux_multB = mult_b_sel;
                mux_Z     = `MUX_Z_MULT_UPPER;
                mux_R     = `MUX_R_MULT_LOWER;
                state_d   = ST_DONE;
            end

            ST_DIV_ITER: begin
                mux_R = `MUX_R_SUB_KEEP;
                mux_Z = `MUX_Z_SHL_ADD;
                mux_D = `MUX_D_SHR;
                if (div_cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end else begin
                    div_cnt_d = div_cnt_q - 5'd1;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
                unique case (op_q)
                    3'b000: result_sel = 2'b01;
                    3'b001, 3'b010, 3'b011: result_sel = 2'b00;
                    3'b100, 3'b101:
                        result_sel = rs2_zero_q ? 2'b10 : 2'b00;
                    default:
                        result_sel = rs2_zero_q ? 2'b11 : 2'b01;
                endcase
                if (op_q == 3'b100) begin
                    negate_result = (rs1_msb_q ^ rs2_msb_q) & ~rs2_zero_q;
                end else if (op_q == 3'b110) begin
                    negate_result = rs1_msb_q & ~rs2_zero_q;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/m_sequencer.md
M_SEQUENCER -- requirements
Module: m_sequencer

Interface
REQ-001 SHALL have parameter MUL_WAIT, default 2, meaning the number of cycles between mult_a/mult_b capture and a valid product register P.
REQ-002 SHALL have ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- start  in  1  request valid; sampled only in IDLE
- funct3  in  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_msb  in  1  rs1[31]
- rs2_msb  in  1  rs2[31]
- rs2_zero  in  1  rs2 == 0
- mux_R  out  `MUX_R_LENGTH  remainder select
- mux_D  out  `MUX_D_LENGTH  divisor select
- mux_Z  out  `MUX_Z_LENGTH  quotient select
- mux_multA  out  `MUX_MULTA_LENGTH  multiplier A select
- mux_multB  out  `MUX_MULTB_LENGTH  multiplier B select
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result_sel  out  2  result source: 00 Z, 01 R, 10 all-ones, 11 rs1 passthrough
- negate_result  out  1  final result is two's-complemented downstream
REQ-003 SHALL take all select encodings from m_definitions.svh.

Function
REQ-004 SHALL use the FSM states IDLE, LOAD, MUL_ISSUE, MUL_WAIT, MUL_WB, DIV_ITER, DONE.
REQ-005 In IDLE with start=1, SHALL latch funct3, rs1_msb, rs2_msb and rs2_zero, then go to LOAD; start in any other state SHALL be ignored.
REQ-006 busy SHALL be 1 in every state except IDLE.
REQ-007 Signedness per op:
- sA = 1 for MUL, MULH, MULHSU, DIV, REM; 0 otherwise.
- sB = 1 for MUL, MULH, DIV, REM; 0 otherwise.
REQ-008 LOAD, multiply ops: mux_R=A, mux_D=B, mux_Z=ZERO; next state MUL_ISSUE.
REQ-009 LOAD, divide ops:
- mux_R = A_NEG if (sA & rs1_msb), else A.
- mux_D = B_NEG if (sB & rs2_msb), else B.
- mux_Z = ZERO.
- Next state is DONE if rs2_zero, else DIV_ITER.
REQ-010 MUL_ISSUE, MUL_WAIT and MUL_WB SHALL drive mux_multA = R_SIGNED if sA, else R_UNSIGNED, and mux_multB = D_SIGNED if sB, else D_UNSIGNED.
- These values are held through MUL_WB because the datapath's upper-word slice depends on them.
REQ-011 MUL_ISSUE SHALL last 1 cycle; MUL_WAIT SHALL last exactly MUL_WAIT cycles, counted by a down-counter.
REQ-012 MUL_WB SHALL drive mux_Z=MULT_UPPER and mux_R=MULT_LOWER for 1 cycle, then go to DONE.
REQ-013 DIV_ITER SHALL drive mux_R=SUB_KEEP, mux_Z=SHL_ADD, mux_D=SHR for exactly 32 cycles, counted by a 5-bit counter from 31 down to 0, then go to DONE.
REQ-014 DONE SHALL assert done=1 for exactly 1 cycle with result_sel and negate_result valid, then return to IDLE.
- A start coincident with DONE is ignored.
REQ-015 result_sel in DONE:
- MUL → 01.
- MULH, MULHSU, MULHU → 00.
- DIV, DIVU with rs2_zero → 10; otherwise → 00.
- REM, REMU with rs2_zero → 11; otherwise → 01.
REQ-016 negate_result in DONE:
- DIV: (rs1_msb ^ rs2_msb) & ~rs2_zero.
- REM: rs1_msb & ~rs2_zero.
- All other ops: 0.
- negate_result SHALL be 0 outside DONE.
REQ-017 Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) SHALL take the normal 32-iteration path with no special case.
REQ-018 In states where a select is not specified above, SHALL drive mux_R, mux_D and mux_Z = KEEP, and mux_multA, mux_multB = ZERO.
REQ-019 Latency from the start cycle to the done cycle:
- Multiply: 4+MUL_WAIT cycles (6 at default).
- Divide: 34 cycles.
- Divide by zero: 2 cycles.

Reset
REQ-020 resetn=0 SHALL asynchronously force IDLE, clear all counters and latched operands, and drive busy=0, done=0, result_sel=00, negate_result=0, selects per REQ-018; this applies mid-operation.
REQ-021 After resetn deasserts, a start on the first rising edge SHALL be accepted normally.

Verification
REQ-022 MULHU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → done at cycle 6, result_sel=00, datapath Z=0xFFFFFFFE, negate_result=0.
REQ-023 MUL, rs1=0xFFFFFFFD (-3), rs2=7 → done at cycle 6, result_sel=01, R=0xFFFFFFEB (-21).
REQ-024 DIV, rs1=-7, rs2=2 → LOAD selects A_NEG/B; 32 DIV_ITER cycles; done at cycle 34; Z=3, negate_result=1 (result -3). REM on the same operands → R=1, negate_result=1 (result -1).
REQ-025 DIVU with rs2=0 → done at cycle 2, result_sel=10, no DIV_ITER cycle. REM with rs1=5, rs2=0 → result_sel=11, negate_result=0.
REQ-026 DIV, rs1=0x80000000, rs2=0xFFFFFFFF → Z=0x80000000, negate_result=0; REM on the same operands → R=0.
REQ-027 resetn pulsed low at iteration 10 of a DIV, with start held high throughout → outputs at reset values immediately; a new start after release is accepted and completes correctly.
